adc_spi_sampler: RTL and testbench

SPI master for the MCP3002-compatible 10-bit ADC on the oscilloscope board, clocked from the 40 MHz system clock. It derives the ADC serial clock internally with an exact divider, issues the per-frame command word, and shifts in one conversion per frame. It delivers each result as a parallel sample with a one-cycle valid strobe. It replaces the free-running counter-derived sclk in the top level and feeds the sample path that drives the LEDs and oscopeOut.

---
 rtl/adc_spi_sampler.sv | 167 ++++++++++++++++
 tb/tb_adc_spi_sampler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_sampler.sv
// SPI master for an MCP3002-compatible 10-bit ADC: divides clk into a mode-0 sclk,
// sends the start/config command each frame and returns D9..D0 with a one-cycle strobe.
module adc_spi_sampler #(
  parameter int CLK_DIV = 20,
  parameter int CS_HIGH = 40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       channel,
  input  logic       miso,
  output logic       mosi,
  output logic       cs,
  output logic       sclk,
  output logic       busy,
  output logic [9:0] sample,
  output logic       sample_valid
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_GAP} state_t;

  // One counter serves both the sclk half-period and the cs-high gap.
  localparam int CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_TC = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(CS_HIGH - 1);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [4:0]       r_rise, w_rise;
  logic             r_chan, w_chan;
  logic [9:0]       r_shift, w_shift;
  logic             r_mosi, w_mosi;
  logic             r_cs, w_cs;
  logic             r_sclk, w_sclk;
  logic             r_busy, w_busy;
  logic [9:0]       r_sample, w_sample;
  logic             r_valid, w_valid;

  logic             w_div_tc;
  logic [4:0]       w_rise_n;
  logic             w_capture;

  assign w_div_tc  = (r_cnt == DIV_TC);
  assign w_rise_n  = r_rise + 5'd1;
  // Rise 5 carries the ADC null bit; rises 6..15 carry D9..D0.
  assign w_capture = (w_rise_n >= 5'd6) && (w_rise_n <= 5'd15);

  // Command bit presented for rise n: start, single-ended, odd/sign, MSB-first.
  function automatic logic cmd_bit(input logic [4:0] n, input logic ch);
    case (n)
      5'd1, 5'd2, 5'd4: cmd_bit = 1'b1;
      5'd3:             cmd_bit = ch;
      default:          cmd_bit = 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_rise   = r_rise;
    w_chan   = r_chan;
    w_shift  = r_shift;
    w_mosi   = r_mosi;
    w_cs     = r_cs;
    w_sclk   = r_sclk;
    w_busy   = r_busy;
    w_sample = r_sample;
    w_valid  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_SETUP;
          w_cnt   = '0;
          w_rise  = '0;
          w_chan  = channel;
          w_shift = '0;
          w_cs    = 1'b0;
          w_busy  = 1'b1;
          w_mosi  = 1'b1;
        end
      end

      S_SETUP: begin
        if (w_div_tc) begin
          w_state = S_XFER;
          w_cnt   = '0;
          w_sclk  = 1'b1;
          w_rise  = w_rise_n;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_XFER: begin
        if (w_div_tc) begin
          w_cnt = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
            w_rise = w_rise_n;
            if (w_capture) w_shift = {r_shift[8:0], miso};
          end else begin
            w_sclk = 1'b0;
            w_mosi = cmd_bit(w_rise_n, r_chan);
            if (r_rise == 5'd16) begin
              w_state  = S_GAP;
              w_cs     = 1'b1;
              w_sample = r_shift;
              w_valid  = 1'b1;
            end
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (r_cnt == GAP_TC) begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_busy  = 1'b0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rise   <= '0;
      r_chan   <= 1'b0;
      r_shift  <= '0;
      r_mosi   <= 1'b0;
      r_cs     <= 1'b1;
      r_sclk   <= 1'b0;
      r_busy   <= 1'b0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_rise   <= w_rise;
      r_chan   <= w_chan;
      r_shift  <= w_shift;
      r_mosi   <= w_mosi;
      r_cs     <= w_cs;
      r_sclk   <= w_sclk;
      r_busy   <= w_busy;
      r_sample <= w_sample;
      r_valid  <= w_valid;
    end
  end

  assign mosi         = r_mosi;
  assign cs           = r_cs;
  assign sclk         = r_sclk;
  assign busy         = r_busy;
  assign sample       = r_sample;
  assign sample_valid = r_valid;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: behavioural ADC models drive miso, and frame-level
// observations (edge times, command bits, results) are compared with expected figures.
`timescale 1ns/1ps
module tb_adc_spi_sampler;

  localparam int DIV       = 20;
  localparam int CSH       = 40;
  localparam int T_RISE1   = 1 + DIV;
  localparam int T_VALID   = 1 + 32 * DIV;
  localparam int T_IDLE    = T_VALID + CSH;
  localparam int T_NEXT_CS = 2 + 32 * DIV + CSH;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, channel = 1'b0, miso = 1'b0;
  logic       mosi, cs, sclk, busy, sample_valid;
  logic [9:0] sample;

  logic       f_start = 1'b0, f_miso = 1'b0;
  logic       f_mosi, f_cs, f_sclk, f_busy, f_valid;
  logic [9:0] f_sample;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  adc_spi_sampler #(.CLK_DIV(DIV), .CS_HIGH(CSH)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .channel(channel), .miso(miso),
    .mosi(mosi), .cs(cs), .sclk(sclk), .busy(busy), .sample(sample),
    .sample_valid(sample_valid)
  );

  adc_spi_sampler #(.CLK_DIV(1), .CS_HIGH(1)) u_fast (
    .clk(clk), .reset_n(reset_n), .start(f_start), .channel(1'b0), .miso(f_miso),
    .mosi(f_mosi), .cs(f_cs), .sclk(f_sclk), .busy(f_busy), .sample(f_sample),
    .sample_valid(f_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC answer for rise n of a frame: D9..D0 on rises 6..15, junk elsewhere.
  function automatic logic adc_bit(input int n, input logic [9:0] d);
    if (n >= 6 && n <= 15) return d[15 - n];
    return 1'($urandom);
  endfunction

  logic [9:0] adc_q[$];
  logic [9:0] adc_cur = '0;
  int         adc_rises = 0;
  logic       adc_cs_d = 1'b1, adc_sclk_d = 1'b0;

  always @(negedge clk) begin
    if (cs) adc_rises = 0;
    else begin
      if (adc_cs_d) begin
        adc_cur = '0;
        if (adc_q.size() > 0) adc_cur = adc_q.pop_front();
      end
      if (sclk && !adc_sclk_d) adc_rises++;
    end
    if (!sclk) miso = adc_bit(adc_rises + 1, adc_cur);
    adc_cs_d   = cs;
    adc_sclk_d = sclk;
  end

  int   f_adc_rises = 0;
  logic f_sclk_d = 1'b0;

  always @(negedge clk) begin
    if (f_cs) f_adc_rises = 0;
    else if (f_sclk && !f_sclk_d) f_adc_rises++;
    if (!f_sclk) f_miso = adc_bit(f_adc_rises + 1, 10'h001);
    f_sclk_d = f_sclk;
  end

  // Follows one frame of the main DUT; c0 is the clk edge that samples start in IDLE,
  // so rel = 1 is the first cycle with cs low.
  task automatic watch_frame(input string tag, input logic [9:0] exp_data, input logic exp_ch,
                             input int c0, input int start_len, input int poke_at,
                             input int flip_at, output int t_valid_abs);
    int rel, rises, n_valid, t_rise1, t_valid, t_idle, run, bad_duty, cs_glitch, cs_gap, tail;
    logic [3:0] cmd;
    logic [9:0] got;
    logic p_sclk;
    rises = 0; n_valid = 0; t_rise1 = -1; t_valid = -1; t_idle = -1; run = 0;
    bad_duty = 0; cs_glitch = 0; cs_gap = 0; tail = 0; cmd = '0; got = '0; p_sclk = 1'b0;
    for (int k = 0; k < T_IDLE + 50 && t_idle < 0; k++) begin
      @(negedge clk);
      rel = cyc - c0 + 1;
      if (rel == 1) begin
        check({tag, " cs_low_at_1"}, cs, 1'b0);
        check({tag, " busy_at_1"}, busy, 1'b1);
      end
      if (start_len > 0 && rel == start_len) start = 1'b0;
      if (rel == poke_at) start = 1'b1;
      if (rel == poke_at + 1) start = 1'b0;
      if (rel == flip_at) channel = ~channel;
      if (sclk != p_sclk) begin
        if ((p_sclk || rises > 0) && run != DIV) bad_duty++;
        run = 0;
        if (sclk) begin
          rises++;
          if (rises == 1) t_rise1 = rel;
          if (rises <= 4) cmd[4 - rises] = mosi;
          else if (mosi) tail++;
        end
      end
      run++;
      p_sclk = sclk;
      if (cs && !sample_valid && t_valid < 0) cs_glitch++;
      if (sample_valid) begin
        n_valid++;
        t_valid = rel;
        got = sample;
        check({tag, " cs_high_at_valid"}, cs, 1'b1);
        check({tag, " sclk_low_at_valid"}, sclk, 1'b0);
      end
      if (cs && t_valid >= 0) cs_gap++;
      if (!busy) t_idle = rel;
    end
    check({tag, " cmd_bits"}, cmd, {1'b1, 1'b1, exp_ch, 1'b1});
    check({tag, " mosi_tail_zero"}, tail, 0);
    check({tag, " rise_count"}, rises, 16);
    check({tag, " first_rise"}, t_rise1, T_RISE1);
    check({tag, " duty_errors"}, bad_duty, 0);
    check({tag, " valid_count"}, n_valid, 1);
    check({tag, " valid_time"}, t_valid, T_VALID);
    check({tag, " sample"}, got, exp_data);
    check({tag, " cs_glitch"}, cs_glitch, 0);
    check({tag, " busy_fall"}, t_idle, T_IDLE);
    check({tag, " cs_high_run"}, cs_gap, CSH + 1);
    t_valid_abs = t_valid + c0 - 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tv, tv_prev, bad, c0, rel, f_bad, f_rises, f_nv, f_tv;
    logic [9:0] d, f_got;
    logic ch, fp;
    logic [9:0] cont_data[3];

    repeat (3) @(negedge clk);
    check("reset_outputs", {cs, sclk, mosi, busy, sample_valid, sample},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000});
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    adc_q.push_back(10'h2A5);
    channel = 1'b0; start = 1'b1;
    watch_frame("single", 10'h2A5, 1'b0, cyc + 1, 1, -1, -1, tv);

    repeat (3) @(negedge clk);
    d = 10'($urandom);
    adc_q.push_back(d);
    channel = 1'b1; start = 1'b1;
    watch_frame("chan_latch", d, 1'b1, cyc + 1, 1, -1, 100, tv);
    repeat (3) @(negedge clk);
    d = 10'($urandom);
    adc_q.push_back(d);
    start = 1'b1;
    watch_frame("chan_next", d, 1'b0, cyc + 1, 1, -1, -1, tv);

    repeat (5) @(negedge clk);
    cont_data = '{10'h3FF, 10'h000, 10'h155};
    for (int i = 0; i < 3; i++) adc_q.push_back(cont_data[i]);
    channel = 1'b1; start = 1'b1;
    tv_prev = 0;
    for (int i = 0; i < 3; i++) begin
      watch_frame($sformatf("cont%0d", i), cont_data[i], 1'b1, cyc + 1,
                  (i == 2) ? 1 : 0, -1, -1, tv);
      if (i > 0) check($sformatf("cont%0d valid_spacing", i), tv - tv_prev, T_NEXT_CS - 1);
      tv_prev = tv;
    end

    for (int i = 0; i < 3; i++) begin
      repeat (1 + $urandom_range(0, 7)) @(negedge clk);
      d  = 10'($urandom);
      ch = 1'($urandom);
      adc_q.push_back(d);
      channel = ch; start = 1'b1;
      watch_frame($sformatf("rand%0d", i), d, ch, cyc + 1, 1, -1, -1, tv);
    end

    repeat (4) @(negedge clk);
    adc_q.push_back(10'h0C3);
    channel = 1'b0; start = 1'b1;
    watch_frame("busy_start", 10'h0C3, 1'b0, cyc + 1, 1, 400, -1, tv);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (!cs || busy || sclk) bad++;
    end
    check("busy_start no_extra_frame", bad, 0);

    adc_q.push_back(10'h3C3);
    channel = 1'b1; start = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    rel = cyc - c0 + 1;
    while (rel < 300) begin
      @(negedge clk);
      rel = cyc - c0 + 1;
    end
    reset_n = 1'b0;
    #1;
    check("midreset outputs", {cs, sclk, mosi, busy, sample_valid, sample},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000});
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (sample_valid || !cs || busy || sclk) bad++;
    end
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (sample_valid || sample != 10'h000 || busy) bad++;
    end
    check("midreset held_quiet", bad, 0);
    d = 10'($urandom);
    adc_q.push_back(d);
    channel = 1'b0; start = 1'b1;
    watch_frame("post_reset", d, 1'b0, cyc + 1, 1, -1, -1, tv);

    repeat (3) @(negedge clk);
    f_bad = 0; f_rises = 0; f_nv = 0; f_tv = -1; f_got = '0; fp = 1'b0;
    f_start = 1'b1;
    c0 = cyc + 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rel = cyc - c0 + 1;
      if (rel == 1) f_start = 1'b0;
      if (f_sclk !== (rel >= 2 && rel <= 33 && (rel % 2) == 0)) f_bad++;
      if (f_sclk && !fp) f_rises++;
      fp = f_sclk;
      if (f_valid) begin
        f_nv++;
        f_tv  = rel;
        f_got = f_sample;
      end
    end
    check("fast sclk_pattern", f_bad, 0);
    check("fast rise_count", f_rises, 16);
    check("fast valid_count", f_nv, 1);
    check("fast valid_time", f_tv, 33);
    check("fast sample", f_got, 10'h001);
    check("fast idle_after", {f_busy, f_cs}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
